// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 64-bit RV64M multiply/divide (shift-add, restoring divide) with 1-cycle div-by-zero/overflow path
module mul_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [63:0] op_a,
  input  logic [63:0] op_b,
  input  logic [4:0]  rd_in,
  output logic        busy,
  output logic        done,
  output logic [63:0] result,
  output logic [4:0]  rd_out
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t r_state;
  logic [127:0] r_p;
  logic [63:0] r_b, r_result;
  logic [5:0] r_cnt;
  logic [1:0] r_f3;
  logic [4:0] r_rd, r_rd_out;
  logic r_na, r_nb, r_busy, r_done;
  logic w_acc, w_sa, w_sb, w_na, w_nb, w_dz, w_ov, w_ge;
  logic [63:0] w_ma, w_mb, w_sp_res, w_dif, w_q, w_r, w_res;
  logic [64:0] w_sum, w_t;
  logic [127:0] w_np, w_prod;
  assign w_acc = start && !r_busy;
  assign w_sa = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3[2] && !funct3[0]);
  assign w_sb = (funct3 == 3'b001) || (funct3[2] && !funct3[0]);
  assign w_na = w_sa && op_a[63];
  assign w_nb = w_sb && op_b[63];
  assign w_ma = w_na ? -op_a : op_a;
  assign w_mb = w_nb ? -op_b : op_b;
  assign w_dz = funct3[2] && (op_b == 64'd0);
  assign w_ov = funct3[2] && !funct3[0] && (op_a == 64'h8000_0000_0000_0000) && (op_b == '1);
  assign w_sp_res = funct3[1] ? (w_dz ? op_a : 64'd0) : (w_dz ? '1 : op_a);
  assign w_sum = {1'b0, r_p[127:64]} + (r_p[0] ? {1'b0, r_b} : 65'd0);
  assign w_t = {r_p[127:64], r_p[63]};
  assign w_ge = w_t >= {1'b0, r_b};
  assign w_dif = w_t[63:0] - r_b;
  assign w_np = (r_state == MUL) ? {w_sum, r_p[63:1]} : {w_ge ? w_dif : w_t[63:0], r_p[62:0], w_ge};
  assign w_prod = (r_na ^ r_nb) ? -w_np : w_np;
  assign w_q = (r_na ^ r_nb) ? -w_np[63:0] : w_np[63:0];
  assign w_r = r_na ? -w_np[127:64] : w_np[127:64];
  assign w_res = (r_state == MUL) ? ((r_f3 == 2'b00) ? w_prod[63:0] : w_prod[127:64]) : (r_f3[1] ? w_r : w_q);
  assign busy = r_busy;
  assign done = r_done;
  assign result = r_result;
  assign rd_out = r_rd_out;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_result <= 64'd0;
      r_rd_out <= 5'd0;
    end else begin
      r_done <= 1'b0;
      if (w_acc) begin
        r_p <= {64'd0, w_ma};
        r_b <= w_mb;
        r_cnt <= 6'd0;
        r_f3 <= funct3[1:0];
        r_na <= w_na;
        r_nb <= w_nb;
        r_rd <= rd_in;
        if (w_dz || w_ov) begin
          r_state <= DONE;
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_result <= w_sp_res;
          r_rd_out <= rd_in;
        end else begin
          r_state <= funct3[2] ? DIV : MUL;
          r_busy <= 1'b1;
        end
      end else if (r_busy) begin
        r_p <= w_np;
        r_cnt <= r_cnt + 6'd1;
        if (r_cnt == 6'd63) begin
          r_state <= DONE;
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_result <= w_res;
          r_rd_out <= r_rd;
        end
      end else begin
        r_state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed self-checking bench for mul_div_unit
module tb_mul_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [2:0] funct3 = 3'd0;
  logic [63:0] op_a = 64'd0, op_b = 64'd0;
  logic [4:0] rd_in = 5'd0;
  logic busy, done;
  logic [63:0] result;
  logic [4:0] rd_out;
  int vectors = 0;
  int errs = 0;
  mul_div_unit dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .op_a(op_a), .op_b(op_b),
    .rd_in(rd_in), .busy(busy), .done(done), .result(result), .rd_out(rd_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic launch(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
    funct3 = f;
    op_a = a;
    op_b = b;
    rd_in = rd;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    funct3 = 3'($urandom);
    op_a = {$urandom, $urandom};
    op_b = {$urandom, $urandom};
    rd_in = 5'($urandom);
  endtask
  task automatic wait_check(input string tag, input int n0, input int exp_n, input logic [63:0] exp_res, input logic [4:0] exp_rd);
    int n;
    logic bok;
    n = n0;
    bok = 1'b1;
    while (!done && n < 100) begin
      if (busy !== 1'b1) bok = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "/done_cycle"}, 64'(n), 64'(exp_n));
    chk({tag, "/busy_while_iterating"}, 64'(bok), 64'd1);
    chk({tag, "/done"}, 64'(done), 64'd1);
    chk({tag, "/busy_at_done"}, 64'(busy), 64'd0);
    chk({tag, "/result"}, result, exp_res);
    chk({tag, "/rd_out"}, 64'(rd_out), 64'(exp_rd));
  endtask
  initial begin
    logic seen;
    repeat (2) @(posedge clk);
    #1;
    chk("reset/busy", 64'(busy), 64'd0);
    chk("reset/done", 64'(done), 64'd0);
    chk("reset/result", result, 64'd0);
    chk("reset/rd_out", 64'(rd_out), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    launch(3'b000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5);
    wait_check("mul_7x-3", 1, 65, 64'hFFFF_FFFF_FFFF_FFEB, 5'd5);
    @(posedge clk);
    #1;
    chk("mul/done_pulse_ends", 64'(done), 64'd0);
    chk("mul/idle_not_busy", 64'(busy), 64'd0);
    chk("mul/result_held", result, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("mul/rd_held", 64'(rd_out), 64'd5);
    launch(3'b011, '1, '1, 5'd6);
    wait_check("mulhu_max", 1, 65, 64'hFFFF_FFFF_FFFF_FFFE, 5'd6);
    launch(3'b001, '1, '1, 5'd7);
    wait_check("mulh_-1x-1", 1, 65, 64'd0, 5'd7);
    launch(3'b010, '1, '1, 5'd8);
    wait_check("mulhsu_-1xmax", 1, 65, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8);
    launch(3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd10);
    wait_check("div_-7/2", 1, 65, 64'hFFFF_FFFF_FFFF_FFFD, 5'd10);
    launch(3'b110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd11);
    wait_check("rem_-7/2", 1, 65, 64'hFFFF_FFFF_FFFF_FFFF, 5'd11);
    launch(3'b101, 64'd100, 64'd7, 5'd12);
    wait_check("divu_100/7", 1, 65, 64'd14, 5'd12);
    launch(3'b111, 64'd100, 64'd7, 5'd13);
    wait_check("remu_100/7", 1, 65, 64'd2, 5'd13);
    launch(3'b101, 64'd5, 64'd0, 5'd14);
    wait_check("divu_5/0", 1, 1, '1, 5'd14);
    launch(3'b110, 64'h8000_0000_0000_0000, '1, 5'd15);
    wait_check("rem_ovf", 1, 1, 64'd0, 5'd15);
    launch(3'b100, 64'h8000_0000_0000_0000, '1, 5'd16);
    wait_check("div_ovf", 1, 1, 64'h8000_0000_0000_0000, 5'd16);
    launch(3'b000, 64'd3, 64'd5, 5'd9);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    funct3 = 3'b101;
    op_a = 64'd5;
    op_b = 64'd0;
    rd_in = 5'd31;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_check("ignored_start", 11, 65, 64'd15, 5'd9);
    launch(3'b000, 64'd6, 64'd7, 5'd1);
    wait_check("b2b_first", 1, 65, 64'd42, 5'd1);
    launch(3'b101, 64'd100, 64'd7, 5'd2);
    wait_check("b2b_second", 1, 65, 64'd14, 5'd2);
    launch(3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd7);
    repeat (29) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    funct3 = 3'b101;
    op_a = 64'd5;
    op_b = 64'd0;
    rd_in = 5'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;
    chk("abort/busy", 64'(busy), 64'd0);
    chk("abort/done", 64'(done), 64'd0);
    chk("abort/result", result, 64'd0);
    chk("abort/rd_out", 64'(rd_out), 64'd0);
    seen = 1'b0;
    repeat (80) begin
      if (done || busy) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    chk("abort/no_activity_after", 64'(seen), 64'd0);
    launch(3'b101, 64'd100, 64'd7, 5'd4);
    wait_check("after_reset", 1, 65, 64'd14, 5'd4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
